image_stream_gen: RTL
=====================

Name: image_stream_gen

Overview:
- Synthetic image-stream transmitter: drives the dvi/dtype/y/u/v/meta_data pixel protocol consumed by imaging blocks such as unsharp_mask.
- Emits framed rows of pixels with a selectable test pattern, programmable geometry and blanking.
- Used as the stimulus source in sims and as an on-chip test-pattern source ahead of the processing chain.

Parameters:
- PIXEL_WIDTH, 10, bits per y/u/v sample.
- DIM_WIDTH, 12, width of row/column counters and geometry inputs.
- BLANK_WIDTH, 16, width of blanking counters.

Ports:
- clk  input  1  pipeline clock.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  run request; sampled only in IDLE and at end of VBLANK.
- num_rows  input  DIM_WIDTH  rows per frame; latched at frame start.
- num_cols  input  DIM_WIDTH  pixels per row; latched at frame start.
- hblank  input  BLANK_WIDTH  idle cycles between ROW_END and the next ROW_START; latched at frame start.
- vblank  input  BLANK_WIDTH  idle cycles after FRAME_END; latched at frame start.
- pattern  input  2  0=ramp, 1=constant, 2=checker, 3=frame counter; latched at frame start.
- const_val  input  PIXEL_WIDTH  value used by the constant pattern.
- dvo  output  1  data valid, high for exactly one cycle per emitted word.
- dtypeo  output  `DTYPE_WIDTH  word type, using the dtypes.v codes FRAME_START, ROW_START, PIXEL, ROW_END, FRAME_END.
- yo, uo, vo  output  PIXEL_WIDTH each  pixel samples; zero on non-PIXEL words.
- meta_datao  output  16  FRAME_START: frame_count; ROW_START: row index; PIXEL: column index; ROW_END/FRAME_END: 0.
- busy  output  1  high in every state except IDLE.
- frame_count  output  16  number of completed frames; wraps at 0xFFFF to 0.

Behaviour:
- Reset (async, reset=1): state=IDLE; dvo=0; dtypeo=0; yo/uo/vo=0; meta_datao=0; busy=0; frame_count=0. All outputs are registered.
- States: IDLE, FSTART, RSTART, PIX, REND, HBLANK, FEND, VBLANK.
- IDLE: if enable=1 and num_rows!=0 and num_cols!=0, latch the config and go to FSTART. If either dimension is 0, stay in IDLE with busy=0.
- FSTART (1 cycle, dvo=1) -> RSTART with row=0.
- RSTART (1 cycle, dvo=1) -> PIX with col=0.
- PIX: num_cols cycles, dvo=1 on every one, col incrementing. Goes to REND after col=num_cols-1.
- REND (1 cycle, dvo=1):
  - last row: go to FEND, with no hblank after the last row;
  - hblank=0: go straight to RSTART with row+1;
  - otherwise: go to HBLANK.
- HBLANK: hblank cycles with dvo=0, then RSTART with row+1.
- FEND (1 cycle, dvo=1): frame_count increments in this cycle. Then VBLANK if vblank!=0, else the end-of-vblank decision below.
- VBLANK: vblank cycles with dvo=0. At the end: enable=1 (with nonzero dims) -> FSTART with fresh config latch; else IDLE.
- enable deasserted mid-frame: the current frame always completes, including FEND and vblank; only then go to IDLE.
- Frame length in cycles = 2 + rows*(cols+2) + (rows-1)*hblank + vblank.
- Config changes mid-frame have no effect until the next latch.
- Patterns (PIXEL words only; u=v=1<<(PIXEL_WIDTH-1) for all patterns):
  - ramp: y = (row+col) truncated to PIXEL_WIDTH.
  - constant: y = const_val.
  - checker: y = all-ones when (row[3]^col[3]) else 0, i.e. 8x8 squares.
  - frame counter: y = frame_count[PIXEL_WIDTH-1:0].
- Idle cycles (HBLANK, VBLANK, IDLE): dvo=0; dtypeo, y/u/v and meta_datao are driven to 0.
- The generator has no backpressure; downstream blocks must accept one word per cycle.
- Reset asserted mid-frame: immediate return to reset values. No FRAME_END is emitted and frame_count clears.

Test Plan:
- rows=2, cols=3, hblank=2, vblank=4, pattern=0, enable held at 1.
  - Sequence: FS, RS, P(y=0,1,2), RE, 2 idle, RS, P(y=1,2,3), RE, FE, 4 idle, next FS.
  - Frame length = 2 + 2*5 + 2 + 4 = 18 cycles; meta on PIXEL = 0,1,2.
- hblank=0, vblank=0, rows=1, cols=1: continuous FS, RS, P, RE, FE, FS... with dvo=1 every cycle; frame_count increments every 5 cycles.
- enable dropped during row 0 of a 4x4 frame: all 4 rows, FE and vblank still emitted, then IDLE with busy=0; frame_count=1.
- num_cols=0 with enable=1: stays IDLE, dvo never asserts, busy=0.
- pattern=2, rows=16, cols=16: y is 0x3FF exactly where row[3]^col[3]=1; u=v=0x200.
- Reset pulsed mid-PIX: next cycle outputs are all 0, state is IDLE, frame_count=0; a restart then begins with FS and meta_datao=0.

Source files
------------

// File: rtl/image_stream_if.sv
// Pixel stream bus carried between image_stream_gen and downstream imaging blocks.
// The transmitter drives every field; the receiver only samples.
`timescale 1ns/1ps
interface image_stream_if #(
  parameter int PIXEL_WIDTH = 10,
  parameter int DTYPE_WIDTH = 4
);
  logic                   dvo;
  logic [DTYPE_WIDTH-1:0] dtypeo;
  logic [PIXEL_WIDTH-1:0] yo;
  logic [PIXEL_WIDTH-1:0] uo;
  logic [PIXEL_WIDTH-1:0] vo;
  logic [15:0]            meta_datao;

  modport master (output dvo, dtypeo, yo, uo, vo, meta_datao);
  modport slave  (input  dvo, dtypeo, yo, uo, vo, meta_datao);
endinterface

// File: rtl/image_stream_gen.sv
// Synthetic framed pixel-stream source with programmable geometry, blanking and
// four test patterns; one word per cycle, no backpressure.
`timescale 1ns/1ps
module image_stream_gen #(
  parameter int PIXEL_WIDTH = 10,
  parameter int DIM_WIDTH   = 12,
  parameter int BLANK_WIDTH = 16,
  parameter int DTYPE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [DIM_WIDTH-1:0]   num_rows,
  input  logic [DIM_WIDTH-1:0]   num_cols,
  input  logic [BLANK_WIDTH-1:0] hblank,
  input  logic [BLANK_WIDTH-1:0] vblank,
  input  logic [1:0]             pattern,
  input  logic [PIXEL_WIDTH-1:0] const_val,
  image_stream_if.master         stream,
  output logic                   busy,
  output logic [15:0]            frame_count
);

  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_START = DTYPE_WIDTH'(1);
  localparam logic [DTYPE_WIDTH-1:0] DT_FRAME_END   = DTYPE_WIDTH'(2);
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_START   = DTYPE_WIDTH'(3);
  localparam logic [DTYPE_WIDTH-1:0] DT_ROW_END     = DTYPE_WIDTH'(4);
  localparam logic [DTYPE_WIDTH-1:0] DT_PIXEL       = DTYPE_WIDTH'(5);

  localparam logic [PIXEL_WIDTH-1:0] CHROMA_MID = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
  localparam logic [PIXEL_WIDTH-1:0] PIX_ONES   = '1;
  localparam logic [DIM_WIDTH-1:0]   DIM_ONE    = DIM_WIDTH'(1);
  localparam logic [BLANK_WIDTH-1:0] BLANK_ONE  = BLANK_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE, S_FSTART, S_RSTART, S_PIX, S_REND, S_HBLANK, S_FEND, S_VBLANK
  } state_t;

  state_t                 state_reg;
  logic [DIM_WIDTH-1:0]   row_reg;
  logic [DIM_WIDTH-1:0]   col_reg;
  logic [BLANK_WIDTH-1:0] blank_cnt_reg;
  logic [15:0]            frame_count_reg;
  logic                   busy_reg;

  logic [DIM_WIDTH-1:0]   rows_cfg_reg;
  logic [DIM_WIDTH-1:0]   cols_cfg_reg;
  logic [BLANK_WIDTH-1:0] hblank_cfg_reg;
  logic [BLANK_WIDTH-1:0] vblank_cfg_reg;
  logic [1:0]             pattern_cfg_reg;
  logic [PIXEL_WIDTH-1:0] const_cfg_reg;

  logic                   dvo_reg;
  logic [DTYPE_WIDTH-1:0] dtype_reg;
  logic [PIXEL_WIDTH-1:0] y_reg;
  logic [PIXEL_WIDTH-1:0] u_reg;
  logic [PIXEL_WIDTH-1:0] v_reg;
  logic [15:0]            meta_reg;

  logic                   start_ok;
  logic                   frame_done;
  logic                   load_cfg;
  logic [DIM_WIDTH-1:0]   rows_last;
  logic [DIM_WIDTH-1:0]   cols_last;
  logic [DIM_WIDTH-1:0]   row_inc;
  logic [DIM_WIDTH-1:0]   col_inc;

  assign start_ok   = enable && (num_rows != '0) && (num_cols != '0);
  // The last cycle of a frame: FEND when there is no vblank, else the final vblank cycle.
  assign frame_done = ((state_reg == S_FEND) && (vblank_cfg_reg == '0)) ||
                      ((state_reg == S_VBLANK) && (blank_cnt_reg == '0));
  assign load_cfg   = start_ok && ((state_reg == S_IDLE) || frame_done);
  assign rows_last  = rows_cfg_reg - DIM_ONE;
  assign cols_last  = cols_cfg_reg - DIM_ONE;
  assign row_inc    = row_reg + DIM_ONE;
  assign col_inc    = col_reg + DIM_ONE;

  function automatic logic [PIXEL_WIDTH-1:0] pixel_y(
    input logic [1:0]             pat,
    input logic [DIM_WIDTH-1:0]   r,
    input logic [DIM_WIDTH-1:0]   c,
    input logic [PIXEL_WIDTH-1:0] cv,
    input logic [15:0]            fc
  );
    logic [DIM_WIDTH:0] sum;
    sum = {1'b0, r} + {1'b0, c};
    case (pat)
      2'd0:    return PIXEL_WIDTH'(sum);
      2'd1:    return cv;
      2'd2:    return (r[3] ^ c[3]) ? PIX_ONES : '0;
      default: return PIXEL_WIDTH'(fc);
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rows_cfg_reg    <= '0;
      cols_cfg_reg    <= '0;
      hblank_cfg_reg  <= '0;
      vblank_cfg_reg  <= '0;
      pattern_cfg_reg <= '0;
      const_cfg_reg   <= '0;
    end else if (load_cfg) begin
      rows_cfg_reg    <= num_rows;
      cols_cfg_reg    <= num_cols;
      hblank_cfg_reg  <= hblank;
      vblank_cfg_reg  <= vblank;
      pattern_cfg_reg <= pattern;
      const_cfg_reg   <= const_val;
    end
  end

  // state_reg names the word currently on the outputs; each branch registers the next word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      row_reg         <= '0;
      col_reg         <= '0;
      blank_cnt_reg   <= '0;
      frame_count_reg <= '0;
      busy_reg        <= 1'b0;
      dvo_reg         <= 1'b0;
      dtype_reg       <= '0;
      y_reg           <= '0;
      u_reg           <= '0;
      v_reg           <= '0;
      meta_reg        <= '0;
    end else begin
      dvo_reg   <= 1'b0;
      dtype_reg <= '0;
      y_reg     <= '0;
      u_reg     <= '0;
      v_reg     <= '0;
      meta_reg  <= '0;
      busy_reg  <= 1'b1;
      case (state_reg)
        S_IDLE: begin
          if (start_ok) begin
            state_reg <= S_FSTART;
            dvo_reg   <= 1'b1;
            dtype_reg <= DT_FRAME_START;
            meta_reg  <= frame_count_reg;
          end else begin
            busy_reg  <= 1'b0;
          end
        end
        S_FSTART: begin
          row_reg   <= '0;
          state_reg <= S_RSTART;
          dvo_reg   <= 1'b1;
          dtype_reg <= DT_ROW_START;
        end
        S_RSTART: begin
          col_reg   <= '0;
          state_reg <= S_PIX;
          dvo_reg   <= 1'b1;
          dtype_reg <= DT_PIXEL;
          y_reg     <= pixel_y(pattern_cfg_reg, row_reg, '0, const_cfg_reg, frame_count_reg);
          u_reg     <= CHROMA_MID;
          v_reg     <= CHROMA_MID;
        end
        S_PIX: begin
          dvo_reg <= 1'b1;
          if (col_reg == cols_last) begin
            state_reg <= S_REND;
            dtype_reg <= DT_ROW_END;
          end else begin
            col_reg   <= col_inc;
            dtype_reg <= DT_PIXEL;
            y_reg     <= pixel_y(pattern_cfg_reg, row_reg, col_inc, const_cfg_reg, frame_count_reg);
            u_reg     <= CHROMA_MID;
            v_reg     <= CHROMA_MID;
            meta_reg  <= 16'(col_inc);
          end
        end
        S_REND: begin
          if (row_reg == rows_last) begin
            state_reg       <= S_FEND;
            dvo_reg         <= 1'b1;
            dtype_reg       <= DT_FRAME_END;
            frame_count_reg <= frame_count_reg + 16'd1;
          end else if (hblank_cfg_reg == '0) begin
            row_reg   <= row_inc;
            state_reg <= S_RSTART;
            dvo_reg   <= 1'b1;
            dtype_reg <= DT_ROW_START;
            meta_reg  <= 16'(row_inc);
          end else begin
            blank_cnt_reg <= hblank_cfg_reg - BLANK_ONE;
            state_reg     <= S_HBLANK;
          end
        end
        S_HBLANK: begin
          if (blank_cnt_reg == '0) begin
            row_reg   <= row_inc;
            state_reg <= S_RSTART;
            dvo_reg   <= 1'b1;
            dtype_reg <= DT_ROW_START;
            meta_reg  <= 16'(row_inc);
          end else begin
            blank_cnt_reg <= blank_cnt_reg - BLANK_ONE;
          end
        end
        S_FEND, S_VBLANK: begin
          if (frame_done) begin
            if (start_ok) begin
              state_reg <= S_FSTART;
              dvo_reg   <= 1'b1;
              dtype_reg <= DT_FRAME_START;
              meta_reg  <= frame_count_reg;
            end else begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end
          end else if (state_reg == S_FEND) begin
            blank_cnt_reg <= vblank_cfg_reg - BLANK_ONE;
            state_reg     <= S_VBLANK;
          end else begin
            blank_cnt_reg <= blank_cnt_reg - BLANK_ONE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign stream.dvo        = dvo_reg;
  assign stream.dtypeo     = dtype_reg;
  assign stream.yo         = y_reg;
  assign stream.uo         = u_reg;
  assign stream.vo         = v_reg;
  assign stream.meta_datao = meta_reg;
  assign busy              = busy_reg;
  assign frame_count       = frame_count_reg;

endmodule
